controller_spi_rx: RTL and testbench

//  Receives the raw serial stream from the handheld controller chip (chip_clk_raw / chip_data_raw),

---
 rtl/controller_pkg.sv | 29 ++
 rtl/spi_byte_deserializer.sv | 83 ++++++++
 rtl/controller_spi_rx.sv | 120 ++++++++++++
 tb/tb_controller_spi_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and constants for the controller serial receiver
// The packet checksum helper is only used when CONTROLLER_CHECKSUM_EN is defined.
package controller_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam logic [7:0] JOY_CENTRE        = 8'h80;

   typedef enum logic [2:0] {HUNT, BTN, JX, JY, CSUM} rx_state_t;

   typedef struct packed {
      logic [7:0] buttons;
      logic [7:0] joystick_x;
      logic [7:0] joystick_y;
   } controller_state_t;

   localparam controller_state_t CTL_RESET = '{
      buttons:    8'h00,
      joystick_x: JOY_CENTRE,
      joystick_y: JOY_CENTRE
   };

   function automatic logic [7:0] packet_checksum(input logic [7:0] sync_b,
                                                  input logic [7:0] btn,
                                                  input logic [7:0] jx,
                                                  input logic [7:0] jy);
      return sync_b ^ btn ^ jx ^ jy;
   endfunction

endpackage

// File: rtl/spi_byte_deserializer.sv
// rtl/spi_byte_deserializer.sv - synchronises the raw controller clock/data and assembles MSB-first bytes
// Also owns the inactivity timeout that realigns the bit counter when the chip clock stalls.
module spi_byte_deserializer #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       chip_clk_raw_i,
   input  logic       chip_data_raw_i,
   output logic       byte_done_o,
   output logic [7:0] byte_data_o,
   output logic       timeout_pulse_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;
   logic [7:0]             shift_q;
   logic [7:0]             shift_d;
   logic [2:0]             bit_cnt_q;
   logic [TW-1:0]          tmo_q;
   logic                   byte_done_q;
   logic [7:0]             byte_q;
   logic                   timeout_q;

   logic clk_s;
   logic data_s;
   logic chip_rise;
   logic tmo_hit;

   assign clk_s     = clk_sync_q[SYNC_STAGES-1];
   assign data_s    = data_sync_q[SYNC_STAGES-1];
   assign chip_rise = clk_s & ~clk_prev_q;
   assign shift_d   = {shift_q[6:0], data_s};
   // The cycle in which the counter would reach the limit; a rising edge that cycle cancels it.
   assign tmo_hit   = !chip_rise && (tmo_q == TMO_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         clk_prev_q  <= 1'b0;
         shift_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         tmo_q       <= '0;
         byte_done_q <= 1'b0;
         byte_q      <= 8'h00;
         timeout_q   <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], chip_clk_raw_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], chip_data_raw_i};
         clk_prev_q  <= clk_s;
         byte_done_q <= 1'b0;
         timeout_q   <= tmo_hit;
         if (chip_rise) begin
            shift_q   <= shift_d;
            tmo_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               byte_done_q <= 1'b1;
               byte_q      <= shift_d;
            end
         end else begin
            if (tmo_q != TMO_MAX) begin
               tmo_q <= tmo_q + TW'(1);
            end
            if (tmo_hit) begin
               bit_cnt_q <= 3'd0;
            end
         end
      end
   end

   assign byte_done_o     = byte_done_q;
   assign byte_data_o     = byte_q;
   assign timeout_pulse_o = timeout_q;

endmodule

// File: rtl/controller_spi_rx.sv
// rtl/controller_spi_rx.sv - frames deserialised controller bytes into button/joystick packets
// Define CONTROLLER_CHECKSUM_EN to require a fifth checksum byte before committing a packet.
module controller_spi_rx
   import controller_pkg::*;
#(
   parameter int         SYNC_STAGES    = 2,
   parameter int         TIMEOUT_CYCLES = 100_000,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       chip_data_raw,
   input  logic       chip_clk_raw,
   output logic [7:0] buttons,
   output logic [7:0] joystick_x,
   output logic [7:0] joystick_y,
   output logic       packet_valid,
   output logic [7:0] last_raw_byte,
   output logic [7:0] frame_errors
);

   logic       byte_done;
   logic [7:0] byte_data;
   logic       timeout_pulse;

   spi_byte_deserializer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_deser (
      .clk_i           (clk_in),
      .rst_i           (rst_in),
      .chip_clk_raw_i  (chip_clk_raw),
      .chip_data_raw_i (chip_data_raw),
      .byte_done_o     (byte_done),
      .byte_data_o     (byte_data),
      .timeout_pulse_o (timeout_pulse)
   );

   rx_state_t         state_q;
   logic [7:0]        btn_q;
   logic [7:0]        jx_q;
`ifdef CONTROLLER_CHECKSUM_EN
   logic [7:0]        jy_q;
`endif
   controller_state_t ctl_q;
   logic              pv_q;
   logic [7:0]        err_q;
   logic [7:0]        err_inc;

   assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   // Staging registers keep the visible outputs untouched until a whole packet is accepted.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= HUNT;
         btn_q   <= 8'h00;
         jx_q    <= 8'h00;
`ifdef CONTROLLER_CHECKSUM_EN
         jy_q    <= 8'h00;
`endif
         ctl_q   <= CTL_RESET;
         pv_q    <= 1'b0;
         err_q   <= 8'h00;
      end else begin
         pv_q <= 1'b0;
         if (timeout_pulse) begin
            if (state_q != HUNT) begin
               err_q <= err_inc;
            end
            state_q <= HUNT;
         end else if (byte_done) begin
            case (state_q)
               HUNT: begin
                  if (byte_data == SYNC_BYTE) begin
                     state_q <= BTN;
                  end
               end
               BTN: begin
                  btn_q   <= byte_data;
                  state_q <= JX;
               end
               JX: begin
                  jx_q    <= byte_data;
                  state_q <= JY;
               end
`ifdef CONTROLLER_CHECKSUM_EN
               JY: begin
                  jy_q    <= byte_data;
                  state_q <= CSUM;
               end
               CSUM: begin
                  if (byte_data == packet_checksum(SYNC_BYTE, btn_q, jx_q, jy_q)) begin
                     ctl_q <= '{buttons: btn_q, joystick_x: jx_q, joystick_y: jy_q};
                     pv_q  <= 1'b1;
                  end else begin
                     err_q <= err_inc;
                  end
                  state_q <= HUNT;
               end
`else
               JY: begin
                  ctl_q   <= '{buttons: btn_q, joystick_x: jx_q, joystick_y: byte_data};
                  pv_q    <= 1'b1;
                  state_q <= HUNT;
               end
`endif
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign buttons       = ctl_q.buttons;
   assign joystick_x    = ctl_q.joystick_x;
   assign joystick_y    = ctl_q.joystick_y;
   assign packet_valid  = pv_q;
   assign last_raw_byte = byte_data;
   assign frame_errors  = err_q;

endmodule

// File: tb/tb_controller_spi_rx.sv
// tb/tb_controller_spi_rx.sv - scoreboard bench for controller_spi_rx with a byte-queue packet model
// Honours CONTROLLER_CHECKSUM_EN for packet length and checksum rule.
module tb_controller_spi_rx;

   localparam int TMO = 200;
`ifdef CONTROLLER_CHECKSUM_EN
   localparam int PKT_LEN = 5;
`else
   localparam int PKT_LEN = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       chip_clk = 1'b0;
   logic       chip_data = 1'b0;
   logic [7:0] buttons;
   logic [7:0] joystick_x;
   logic [7:0] joystick_y;
   logic       packet_valid;
   logic [7:0] last_raw_byte;
   logic [7:0] frame_errors;

   always #5 clk = ~clk;

   controller_spi_rx #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_BYTE      (8'hA5)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .chip_data_raw (chip_data),
      .chip_clk_raw  (chip_clk),
      .buttons       (buttons),
      .joystick_x    (joystick_x),
      .joystick_y    (joystick_y),
      .packet_valid  (packet_valid),
      .last_raw_byte (last_raw_byte),
      .frame_errors  (frame_errors)
   );

   typedef struct {
      logic [7:0] b;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] last;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] pend[$];
   int         model_err = 0;
   logic [7:0] sh_b = 8'h00;
   logic [7:0] sh_x = 8'h80;
   logic [7:0] sh_y = 8'h80;
   int         total = 0;
   int         bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // Reference model: bytes after a sync byte are gathered until a packet is complete.
   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      if (pend.size() == 0) begin
         if (b == 8'hA5) pend.push_back(b);
      end else begin
         pend.push_back(b);
         if (pend.size() == PKT_LEN) begin
            e.b = pend[1]; e.x = pend[2]; e.y = pend[3]; e.last = b;
`ifdef CONTROLLER_CHECKSUM_EN
            if (pend[4] == (pend[0] ^ pend[1] ^ pend[2] ^ pend[3])) exp_q.push_back(e);
            else if (model_err < 255) model_err++;
`else
            exp_q.push_back(e);
`endif
            pend.delete();
         end
      end
   endtask

   task automatic model_timeout();
      if (pend.size() != 0) begin
         if (model_err < 255) model_err++;
         pend.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int half;
      model_byte(b);
      half = $urandom_range(2, 6);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         chip_data = b[i];
         repeat (half) @(negedge clk);
         chip_clk = 1'b1;
         repeat (half) @(negedge clk);
         chip_clk = 1'b0;
      end
   endtask

   task automatic send_packet(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
      send_byte(8'hA5);
      send_byte(b);
      send_byte(x);
      send_byte(y);
`ifdef CONTROLLER_CHECKSUM_EN
      send_byte(8'hA5 ^ b ^ x ^ y);
`endif
   endtask

   task automatic idle_timeout();
      repeat (2 * TMO) @(negedge clk);
      model_timeout();
   endtask

   task automatic settle(input string name);
      repeat (12) @(negedge clk);
      check({name, "_errors"}, {24'd0, frame_errors}, model_err);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      chip_clk = 1'b0;
      chip_data = 1'b0;
      repeat (3) @(negedge clk);
      pend.delete();
      exp_q.delete();
      model_err = 0;
      sh_b = 8'h00; sh_x = 8'h80; sh_y = 8'h80;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (packet_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_packet_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("buttons", buttons, e.b);
               check("joystick_x", joystick_x, e.x);
               check("joystick_y", joystick_y, e.y);
               check("last_raw_byte", last_raw_byte, e.last);
               sh_b = e.b; sh_x = e.x; sh_y = e.y;
            end
         end else begin
            check("outputs_hold", {buttons, joystick_x, joystick_y}, {sh_b, sh_x, sh_y});
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      int k;
      logic [7:0] r;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      do_reset();
      @(negedge clk);
      check("rst_buttons", buttons, 8'h00);
      check("rst_joystick_x", joystick_x, 8'h80);
      check("rst_joystick_y", joystick_y, 8'h80);
      check("rst_frame_errors", frame_errors, 8'h00);
      check("rst_packet_valid", packet_valid, 1'b0);
      check("rst_last_raw_byte", last_raw_byte, 8'h00);

      send_packet(8'h01, 8'h10, 8'hF0);
      settle("good_packet");
`ifdef CONTROLLER_CHECKSUM_EN
      check("good_last_raw", last_raw_byte, 8'h44);
`else
      check("good_last_raw", last_raw_byte, 8'hF0);
`endif

      send_byte(8'h3C);
      send_byte(8'h77);
      send_packet(8'h22, 8'h33, 8'h44);
      settle("garbage_then_packet");

      send_byte(8'hA5);
      send_byte(8'h01);
      idle_timeout();
      settle("timeout_abort");
      check("timeout_count", frame_errors, 8'h01);
      send_packet(8'h5A, 8'h80, 8'h7F);
      settle("after_timeout");

`ifdef CONTROLLER_CHECKSUM_EN
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
      send_byte(8'hF0); send_byte(8'h00);
      settle("bad_checksum");
      check("bad_checksum_count", frame_errors, 8'h02);
`endif

      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      do_reset();
      @(negedge clk);
      check("midrst_buttons", buttons, 8'h00);
      check("midrst_joystick", {joystick_x, joystick_y}, 16'h8080);
      check("midrst_errors", frame_errors, 8'h00);
      send_packet(8'hC3, 8'h01, 8'hFE);
      settle("after_midrst");

      idle_timeout();
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0, 1: send_packet(8'($urandom), 8'($urandom), 8'($urandom));
            2: send_byte(8'($urandom));
            default: begin
               send_byte(8'hA5);
               k = $urandom_range(0, PKT_LEN - 2);
               for (int j = 0; j < k; j++) send_byte(8'($urandom));
               idle_timeout();
            end
         endcase
`ifdef CONTROLLER_CHECKSUM_EN
         if ($urandom_range(0, 5) == 0) begin
            r = 8'($urandom);
            send_byte(8'hA5); send_byte(r); send_byte(8'h00); send_byte(8'hFF);
            send_byte(8'hA5 ^ r ^ 8'hFF ^ 8'h01);
         end
`endif
         repeat ($urandom_range(0, 20)) @(negedge clk);
         repeat (12) @(negedge clk);
         check("rand_errors", {24'd0, frame_errors}, model_err);
      end
      idle_timeout();
      settle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
